// File: rtl/io_serdes_link_ctrl.sv
// Bring-up and supervision sequencer for one IO serdes link: programs the serdes control register
// over AXI-lite (RX, gap, TX, read-back), waits for remote traffic, then watches the TX stream for stalls.
module io_serdes_link_ctrl #(
    parameter int pADDR_WIDTH   = 10,
    parameter int pDATA_WIDTH   = 32,
    parameter int pRX_TX_GAP    = 16,
    parameter int pAXI_TIMEOUT  = 64,
    parameter int pLINK_TIMEOUT = 1024,
    parameter int pSTALL_LIMIT  = 4096
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset,
    input  logic                     start,
    input  logic                     abort,
    output logic                     m_awvalid,
    output logic [pADDR_WIDTH-1:0]   m_awaddr,
    input  logic                     m_awready,
    output logic                     m_wvalid,
    output logic [pDATA_WIDTH-1:0]   m_wdata,
    output logic [pDATA_WIDTH/8-1:0] m_wstrb,
    input  logic                     m_wready,
    output logic                     m_arvalid,
    output logic [pADDR_WIDTH-1:0]   m_araddr,
    input  logic                     m_arready,
    input  logic                     m_rvalid,
    input  logic [pDATA_WIDTH-1:0]   m_rdata,
    output logic                     m_rready,
    input  logic                     rx_link_active,
    input  logic                     as_is_tvalid,
    input  logic                     is_as_tready,
    output logic                     link_up,
    output logic                     link_err,
    output logic [1:0]               err_code,
    output logic                     busy,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_RX     = 3'd1,
        S_GAP       = 3'd2,
        S_WR_TX     = 3'd3,
        S_VERIFY    = 3'd4,
        S_WAIT_LINK = 3'd5,
        S_UP        = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    localparam int AXI_W   = $clog2(pAXI_TIMEOUT + 1);
    localparam int GAP_W   = $clog2(pRX_TX_GAP + 1);
    localparam int LINK_W  = $clog2(pLINK_TIMEOUT + 1);
    localparam int STALL_W = $clog2(pSTALL_LIMIT + 1);

    localparam logic [AXI_W-1:0]   AXI_LIM   = AXI_W'(pAXI_TIMEOUT);
    localparam logic [GAP_W-1:0]   GAP_LIM   = GAP_W'(pRX_TX_GAP);
    localparam logic [LINK_W-1:0]  LINK_LIM  = LINK_W'(pLINK_TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(pSTALL_LIMIT);

    localparam logic [1:0] ERR_AXI    = 2'd0;
    localparam logic [1:0] ERR_VERIFY = 2'd1;
    localparam logic [1:0] ERR_LINK   = 2'd2;
    localparam logic [1:0] ERR_STALL  = 2'd3;

    state_t cur_state, next_state;
    logic [1:0] err_code_d;

    logic awvalid_d, arvalid_d, rready_d, rd_phase, rd_phase_d;
    logic link_up_d, link_err_d, busy_d;

    logic [AXI_W-1:0]   axi_cnt, axi_cnt_d, axi_inc;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d, gap_inc;
    logic [LINK_W-1:0]  link_cnt, link_cnt_d, link_inc;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_d, stall_inc;

    logic in_write, axi_phase, wr_done, ar_hs, rd_done, axi_to, stall;
    logic unused_rdata_hi;

    // Counters hold "cycles already spent", so the +1 value is the cycle being evaluated now.
    assign axi_inc   = axi_cnt + AXI_W'(1);
    assign gap_inc   = gap_cnt + GAP_W'(1);
    assign link_inc  = link_cnt + LINK_W'(1);
    assign stall_inc = stall_cnt + STALL_W'(1);

    assign in_write  = (cur_state == S_WR_RX) || (cur_state == S_WR_TX);
    assign axi_phase = in_write || (cur_state == S_VERIFY);
    assign wr_done   = in_write && m_awvalid && m_awready && m_wvalid && m_wready;
    assign ar_hs     = (cur_state == S_VERIFY) && m_arvalid && m_arready;
    // Read data may arrive in the same cycle the address is accepted.
    assign rd_done   = (cur_state == S_VERIFY) && m_rvalid && (m_rready || ar_hs);
    assign axi_to    = axi_phase && !(wr_done || ar_hs || rd_done) && (axi_inc == AXI_LIM);
    assign stall     = as_is_tvalid && !is_as_tready;

    assign unused_rdata_hi = ^m_rdata[pDATA_WIDTH-1:2];

    assign m_awaddr = '0;
    assign m_araddr = '0;
    assign m_wstrb  = '1;
    assign state    = cur_state;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            cur_state <= S_IDLE;
            err_code  <= 2'd0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            rd_phase  <= 1'b0;
            link_up   <= 1'b0;
            link_err  <= 1'b0;
            busy      <= 1'b0;
            axi_cnt   <= '0;
            gap_cnt   <= '0;
            link_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            cur_state <= next_state;
            err_code  <= err_code_d;
            m_awvalid <= awvalid_d;
            m_wvalid  <= awvalid_d;
            m_arvalid <= arvalid_d;
            m_rready  <= rready_d;
            rd_phase  <= rd_phase_d;
            link_up   <= link_up_d;
            link_err  <= link_err_d;
            busy      <= busy_d;
            axi_cnt   <= axi_cnt_d;
            gap_cnt   <= gap_cnt_d;
            link_cnt  <= link_cnt_d;
            stall_cnt <= stall_cnt_d;
        end
    end

    // Write data is loaded on entry to a write state and held stable until the handshake.
    always_ff @(posedge axi_clk) begin
        if (next_state == S_WR_RX) begin
            m_wdata <= pDATA_WIDTH'(1);
        end else if (next_state == S_WR_TX) begin
            m_wdata <= pDATA_WIDTH'(3);
        end
    end

    always_comb begin
        next_state = cur_state;
        err_code_d = err_code;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (start) next_state = S_WR_RX;
                end
                S_WR_RX: begin
                    if (wr_done) begin
                        next_state = S_GAP;
                    end else if (axi_to) begin
                        next_state = S_ERR;
                        err_code_d = ERR_AXI;
                    end
                end
                S_GAP: begin
                    if (gap_inc == GAP_LIM) next_state = S_WR_TX;
                end
                S_WR_TX: begin
                    if (wr_done) begin
                        next_state = S_VERIFY;
                    end else if (axi_to) begin
                        next_state = S_ERR;
                        err_code_d = ERR_AXI;
                    end
                end
                S_VERIFY: begin
                    if (rd_done) begin
                        if (m_rdata[1:0] == 2'b11) begin
                            next_state = S_WAIT_LINK;
                        end else begin
                            next_state = S_ERR;
                            err_code_d = ERR_VERIFY;
                        end
                    end else if (axi_to) begin
                        next_state = S_ERR;
                        err_code_d = ERR_AXI;
                    end
                end
                S_WAIT_LINK: begin
                    if (rx_link_active) begin
                        next_state = S_UP;
                    end else if (link_inc == LINK_LIM) begin
                        next_state = S_ERR;
                        err_code_d = ERR_LINK;
                    end
                end
                S_UP: begin
                    if (stall && (stall_inc == STALL_LIM)) begin
                        next_state = S_ERR;
                        err_code_d = ERR_STALL;
                    end
                end
                S_ERR: begin
                    if (start) next_state = S_WR_RX;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so that they register in step with the state.
    always_comb begin
        awvalid_d  = (next_state == S_WR_RX) || (next_state == S_WR_TX);
        rd_phase_d = (cur_state == S_VERIFY) && (next_state == S_VERIFY) && (rd_phase || ar_hs);
        arvalid_d  = (next_state == S_VERIFY) && !rd_phase_d;
        rready_d   = rd_phase_d;
        link_up_d  = (next_state == S_UP);
        link_err_d = (next_state == S_ERR);
        busy_d     = !((next_state == S_IDLE) || (next_state == S_UP) || (next_state == S_ERR));
    end

    // Every counter restarts on any state change; the AXI counter also restarts per read handshake.
    always_comb begin
        axi_cnt_d   = '0;
        gap_cnt_d   = '0;
        link_cnt_d  = '0;
        stall_cnt_d = '0;
        if (next_state == cur_state) begin
            if (axi_phase && !ar_hs) begin
                axi_cnt_d = (axi_cnt == AXI_LIM) ? axi_cnt : axi_inc;
            end
            if (cur_state == S_GAP) begin
                gap_cnt_d = (gap_cnt == GAP_LIM) ? gap_cnt : gap_inc;
            end
            if (cur_state == S_WAIT_LINK) begin
                link_cnt_d = (link_cnt == LINK_LIM) ? link_cnt : link_inc;
            end
            if ((cur_state == S_UP) && stall) begin
                stall_cnt_d = (stall_cnt == STALL_LIM) ? stall_cnt : stall_inc;
            end
        end
    end

endmodule

// File: tb/tb_io_serdes_link_ctrl.sv
// Self-checking bench for io_serdes_link_ctrl: scoreboarded AXI-lite writes, table-driven bring-ups,
// plus hand-written sequences for back-pressure, timeouts, stall limit, abort and reset.
module tb_io_serdes_link_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int GAP = 16;
    localparam int AXI_TO = 64;
    localparam int LINK_TO = 1024;
    localparam int STALL_LIM = 4096;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_WR_RX = 3'd1, ST_GAP = 3'd2, ST_WR_TX = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd5, ST_UP = 3'd6, ST_ERR = 3'd7;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        int              cyc;
    } wr_t;

    typedef struct {
        logic [DW-1:0] rd_val;
        bit            fast;
        logic [2:0]    exp_state;
        bit            exp_up;
        bit            exp_err;
        logic [1:0]    exp_code;
    } vec_t;

    logic axi_clk = 1'b0;
    logic axi_reset, start, abort;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW/8-1:0] m_wstrb;
    logic rx_link_active, as_is_tvalid, is_as_tready;
    logic link_up, link_err, busy;
    logic [1:0] err_code;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  rise_q[$];
    int  stab_viol = 0;

    // Read responder state
    bit            fast_rd = 1'b0;
    logic [DW-1:0] rd_val = '0;
    logic          rv_q = 1'b0;
    logic [DW-1:0] rdata_q = '0;
    bit            ar_seen = 1'b0;
    bit            r_seen = 1'b0;

    bit            prev_pend = 1'b0;
    bit            prev_awvalid = 1'b0;
    logic [DW-1:0] prev_wdata = '0;

    vec_t vecs[7];

    io_serdes_link_ctrl #(
        .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pRX_TX_GAP(GAP),
        .pAXI_TIMEOUT(AXI_TO), .pLINK_TIMEOUT(LINK_TO), .pSTALL_LIMIT(STALL_LIM)
    ) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .start(start), .abort(abort),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
        .rx_link_active(rx_link_active), .as_is_tvalid(as_is_tvalid), .is_as_tready(is_as_tready),
        .link_up(link_up), .link_err(link_err), .err_code(err_code), .busy(busy), .state(state)
    );

    always #5 axi_clk = ~axi_clk;

    always @(posedge axi_clk) cyc <= cyc + 1;

    assign m_rvalid = fast_rd ? (m_arvalid && m_arready) : rv_q;
    assign m_rdata  = fast_rd ? rd_val : rdata_q;

    // Monitor: looks at settled values mid-cycle, i.e. what the next rising edge will accept.
    always @(negedge axi_clk) begin
        #1;
        ar_seen = m_arvalid && m_arready && !fast_rd;
        r_seen  = rv_q && m_rready;
        if (!axi_reset && !abort && m_awvalid && m_awready && m_wvalid && m_wready)
            obs_q.push_back('{m_awaddr, m_wdata, m_wstrb, cyc});
        if (prev_pend && m_awvalid && (m_wdata !== prev_wdata || m_wvalid !== 1'b1))
            stab_viol++;
        if (m_awvalid && !prev_awvalid)
            rise_q.push_back(cyc);
        prev_pend    = m_awvalid && !(m_awready && m_wready);
        prev_wdata   = m_wdata;
        prev_awvalid = m_awvalid;
    end

    // Slave read channel: data one cycle after the address handshake, held until taken.
    always @(posedge axi_clk) begin
        #1;
        if (axi_reset) begin
            rv_q = 1'b0;
        end else begin
            if (r_seen) rv_q = 1'b0;
            if (ar_seen) begin
                rv_q    = 1'b1;
                rdata_q = rd_val;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bringup(input bit with_tx);
        exp_q.push_back('{'0, 32'h1, '1, 0});
        if (with_tx) exp_q.push_back('{'0, 32'h3, '1, 0});
    endtask

    task automatic drain_writes(input string tag);
        wr_t e, o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_awaddr"}, 32'(o.addr), 32'(e.addr));
            chk({tag, "_wdata"}, o.data, e.data);
            chk({tag, "_wstrb"}, 32'(o.strb), 32'(e.strb));
        end
        chk({tag, "_writes_left"}, exp_q.size() + obs_q.size(), 0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge axi_clk);
        abort = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
        chk({tag, "_reach_state"}, 32'(state), 32'(s));
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (state !== ST_UP && state !== ST_ERR && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
    endtask

    initial begin
        int busy_bad;
        int n;
        int t0;
        int gap_meas;

        vecs[0] = '{32'h0000_0003, 1'b0, ST_UP,  1'b1, 1'b0, 2'd0};
        vecs[1] = '{32'h0000_0001, 1'b0, ST_ERR, 1'b0, 1'b1, 2'd1};
        vecs[2] = '{32'h0000_0003, 1'b0, ST_UP,  1'b1, 1'b0, 2'd0};
        vecs[3] = '{32'hFFFF_FFF3, 1'b1, ST_UP,  1'b1, 1'b0, 2'd0};
        vecs[4] = '{32'h0000_0002, 1'b1, ST_ERR, 1'b0, 1'b1, 2'd1};
        vecs[5] = '{32'hFFFF_FFF0, 1'b0, ST_ERR, 1'b0, 1'b1, 2'd1};
        vecs[6] = '{32'h0000_0003, 1'b1, ST_UP,  1'b1, 1'b0, 2'd0};

        axi_reset = 1'b1; start = 1'b0; abort = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        rx_link_active = 1'b0; as_is_tvalid = 1'b0; is_as_tready = 1'b0;
        repeat (3) @(negedge axi_clk);

        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_valids", {28'd0, m_awvalid, m_wvalid, m_arvalid, m_rready}, 32'd0);
        chk("rst_status", {29'd0, link_up, link_err, busy}, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        axi_reset = 1'b0;
        @(negedge axi_clk);

        // Basic bring-up: slave always ready, remote already active.
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        rx_link_active = 1'b1; rd_val = 32'h3;
        rise_q.delete();
        push_bringup(1'b1);
        pulse_start();
        chk("t1_wr_rx_entry", 32'(state), 32'(ST_WR_RX));
        busy_bad = 0;
        n = 0;
        while (state !== ST_UP && n < 300) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge axi_clk);
            n++;
        end
        chk("t1_busy_during_bringup", busy_bad, 0);
        chk("t1_state_up", 32'(state), 32'(ST_UP));
        chk("t1_link_up", 32'(link_up), 32'd1);
        chk("t1_busy_in_up", 32'(busy), 32'd0);
        // TX awvalid rises GAP+1 cycles after the RX handshake cycle: GAP idle cycles in between.
        gap_meas = (rise_q.size() >= 2 && obs_q.size() >= 1) ? rise_q[1] - obs_q[0].cyc : -1;
        chk("t1_gap_cycles", gap_meas, GAP + 1);
        drain_writes("t1");

        for (int i = 0; i < 7; i++) begin
            if (state === ST_UP) do_abort();
            rd_val  = vecs[i].rd_val;
            fast_rd = vecs[i].fast;
            push_bringup(1'b1);
            pulse_start();
            chk($sformatf("vec%0d_entry", i), 32'(state), 32'(ST_WR_RX));
            chk($sformatf("vec%0d_err_cleared", i), 32'(link_err), 32'd0);
            wait_end(300);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d_link_up", i), 32'(link_up), 32'(vecs[i].exp_up));
            chk($sformatf("vec%0d_link_err", i), 32'(link_err), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err)
                chk($sformatf("vec%0d_err_code", i), 32'(err_code), 32'(vecs[i].exp_code));
            drain_writes($sformatf("vec%0d", i));
        end
        fast_rd = 1'b0;
        rd_val  = 32'h3;

        // Write with awready but no wready for 10 cycles.
        do_abort();
        m_wready = 1'b0;
        stab_viol = 0;
        push_bringup(1'b1);
        pulse_start();
        repeat (10) @(negedge axi_clk);
        chk("t2_no_write_yet", obs_q.size(), 0);
        chk("t2_awvalid_held", 32'(m_awvalid), 32'd1);
        chk("t2_wdata_held", m_wdata, 32'h1);
        m_wready = 1'b1;
        wait_state(ST_UP, 300, "t2");
        chk("t2_wdata_stable", stab_viol, 0);
        drain_writes("t2");

        // AXI timeout: slave never ready.
        do_abort();
        m_awready = 1'b0; m_wready = 1'b0;
        pulse_start();
        t0 = cyc;
        n = 0;
        while (state === ST_WR_RX && n < 200) begin
            @(negedge axi_clk);
            n++;
        end
        chk("axi_to_cycles", cyc - t0, AXI_TO);
        chk("axi_to_state", 32'(state), 32'(ST_ERR));
        chk("axi_to_code", 32'(err_code), 32'd0);
        chk("axi_to_valids", {30'd0, m_awvalid, m_wvalid}, 32'd0);
        drain_writes("axi_to");

        // Link timeout: remote never becomes active.
        m_awready = 1'b1; m_wready = 1'b1;
        rx_link_active = 1'b0;
        push_bringup(1'b1);
        pulse_start();
        wait_state(ST_WAIT, 300, "t4");
        t0 = cyc;
        n = 0;
        while (state === ST_WAIT && n < LINK_TO + 100) begin
            @(negedge axi_clk);
            n++;
        end
        chk("t4_timeout_cycles", cyc - t0, LINK_TO);
        chk("t4_state", 32'(state), 32'(ST_ERR));
        chk("t4_err_code", 32'(err_code), 32'd2);
        chk("t4_link_err", 32'(link_err), 32'd1);
        drain_writes("t4");
        do_abort();
        chk("abort_err_state", 32'(state), 32'(ST_IDLE));
        chk("abort_err_code_kept", 32'(err_code), 32'd2);
        chk("abort_err_link_err", 32'(link_err), 32'd0);

        // Abort in the middle of the TX write.
        rx_link_active = 1'b1;
        push_bringup(1'b0);
        pulse_start();
        wait_state(ST_GAP, 100, "t6_gap");
        m_awready = 1'b0; m_wready = 1'b0;
        wait_state(ST_WR_TX, 100, "t6_wrtx");
        @(negedge axi_clk);
        chk("t6_awvalid_before_abort", 32'(m_awvalid), 32'd1);
        do_abort();
        chk("t6_abort_state", 32'(state), 32'(ST_IDLE));
        chk("t6_abort_valids", {30'd0, m_awvalid, m_wvalid}, 32'd0);
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_code_kept", 32'(err_code), 32'd2);
        drain_writes("t6");

        // Reset while up.
        m_awready = 1'b1; m_wready = 1'b1;
        push_bringup(1'b1);
        pulse_start();
        wait_state(ST_UP, 300, "t6_up");
        drain_writes("t6_up");
        axi_reset = 1'b1;
        @(negedge axi_clk);
        chk("t6_rst_state", 32'(state), 32'(ST_IDLE));
        chk("t6_rst_status", {29'd0, link_up, link_err, busy}, 32'd0);
        chk("t6_rst_err_code", 32'(err_code), 32'd0);
        chk("t6_rst_valids", {28'd0, m_awvalid, m_wvalid, m_arvalid, m_rready}, 32'd0);
        axi_reset = 1'b0;
        @(negedge axi_clk);

        // Stall limit: 4095 stalls, one ready cycle, then 4096 stalls.
        push_bringup(1'b1);
        pulse_start();
        wait_state(ST_UP, 300, "t5_up");
        drain_writes("t5");
        as_is_tvalid = 1'b1; is_as_tready = 1'b0;
        repeat (STALL_LIM - 1) @(negedge axi_clk);
        chk("t5_first_run_up", 32'(state), 32'(ST_UP));
        is_as_tready = 1'b1;
        @(negedge axi_clk);
        chk("t5_ready_cycle_up", 32'(state), 32'(ST_UP));
        is_as_tready = 1'b0;
        repeat (STALL_LIM - 1) @(negedge axi_clk);
        chk("t5_before_limit_up", 32'(link_up), 32'd1);
        @(negedge axi_clk);
        chk("t5_limit_state", 32'(state), 32'(ST_ERR));
        chk("t5_limit_code", 32'(err_code), 32'd3);
        chk("t5_limit_flags", {30'd0, link_up, link_err}, 32'd1);
        as_is_tvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
